// File: rtl/bp_pkg.sv
// Shared definitions for the local-history branch predictor: widths, counter
// constants and the 2-bit saturating counter update rule.
package bp_pkg;

   localparam int unsigned PC_BITS   = 10;
   localparam int unsigned HIST_BITS = 3;
   localparam int unsigned CTR_BITS  = 2;

   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = 2'b10;
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

   // Move one step toward the outcome, holding at either end.
   function automatic logic [CTR_BITS-1:0] sat_update(input logic [CTR_BITS-1:0] ctr,
                                                      input logic                taken);
      logic [CTR_BITS-1:0] r;
      r = ctr;
      if (taken && (ctr != CTR_MAX)) begin
         r = ctr + CTR_BITS'(1);
      end else if (!taken && (ctr != '0)) begin
         r = ctr - CTR_BITS'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// One pattern-table entry. Exposes its next value so a same-cycle lookup can
// see the post-update counter.
module sat_counter
   import bp_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic                init,
   input  logic [CTR_BITS-1:0] init_val,
   input  logic                taken,
   output logic [CTR_BITS-1:0] ctr_next_c
);

   logic [CTR_BITS-1:0] ctr_q;
   logic [CTR_BITS-1:0] ctr_d;

   always_comb begin
      ctr_d = ctr_q;
      if (we) begin
         ctr_d = init ? init_val : sat_update(ctr_q, taken);
      end
   end

   assign ctr_next_c = ctr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q <= CTR_WEAK_NT;
      end else begin
         ctr_q <= ctr_d;
      end
   end

endmodule

// File: rtl/branch_pattern_table.sv
// Second-level pattern table of the local-history predictor: registered
// prediction from {pc, history}, counter training, and mispredict/lookup stats.
module branch_pattern_table
   import bp_pkg::*;
#(
   parameter int unsigned PC_IDX_BITS = 2,
   parameter int unsigned STAT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pred_req,
   input  logic [PC_BITS-1:0]    pred_pc,
   input  logic [HIST_BITS-1:0]  read_history,
   input  logic                  read_hit,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic                  pred_from_table,
   input  logic                  upd_valid,
   input  logic [PC_BITS-1:0]    upd_pc,
   input  logic [HIST_BITS-1:0]  upd_history,
   input  logic                  upd_evict,
   input  logic                  upd_taken,
   input  logic                  upd_pred_taken,
   output logic                  mispredict,
   output logic [STAT_WIDTH-1:0] mispredict_count,
   output logic [STAT_WIDTH-1:0] lookup_count
);

   localparam int unsigned IDX_W   = PC_IDX_BITS + HIST_BITS;
   localparam int unsigned ENTRIES = 1 << IDX_W;

   logic [IDX_W-1:0]    lkp_idx;
   logic [IDX_W-1:0]    upd_idx;
   logic [CTR_BITS-1:0] evict_val;
   logic [CTR_BITS-1:0] ctr_next [ENTRIES];
   logic [CTR_BITS-1:0] lkp_ctr;
   logic                mp_event;
   logic                unused_pc_bits;

   assign lkp_idx   = {pred_pc[PC_IDX_BITS-1:0], read_history};
   assign upd_idx   = {upd_pc[PC_IDX_BITS-1:0], upd_history};
   assign evict_val = upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
   assign unused_pc_bits = ^{pred_pc[PC_BITS-1:PC_IDX_BITS], upd_pc[PC_BITS-1:PC_IDX_BITS]};

   // Counter array; evict re-seeds an entry weakly in the outcome direction.
   for (genvar i = 0; i < ENTRIES; i++) begin : gen_ctr
      sat_counter u_ctr (
         .clk        (clk),
         .rst        (rst),
         .we         (upd_valid && (upd_idx == IDX_W'(i))),
         .init       (upd_evict),
         .init_val   (evict_val),
         .taken      (upd_taken),
         .ctr_next_c (ctr_next[i])
      );
   end

   // Reading the next value gives write-first behaviour on an index collision.
   assign lkp_ctr  = ctr_next[lkp_idx];
   assign mp_event = upd_valid && (upd_taken != upd_pred_taken);

   logic                  pred_valid_q, pred_valid_d;
   logic                  pred_taken_q, pred_taken_d;
   logic                  pred_from_table_q, pred_from_table_d;
   logic                  mispredict_q, mispredict_d;
   logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
   logic [STAT_WIDTH-1:0] lookup_count_q, lookup_count_d;

   always_comb begin
      pred_valid_d       = 1'b0;
      pred_taken_d       = pred_taken_q;
      pred_from_table_d  = pred_from_table_q;
      mispredict_d       = mp_event;
      mispredict_count_d = mispredict_count_q;
      lookup_count_d     = lookup_count_q;

      if (pred_req) begin
         pred_valid_d      = 1'b1;
         pred_taken_d      = read_hit && lkp_ctr[CTR_BITS-1];
         pred_from_table_d = read_hit;
         if (lookup_count_q != '1) begin
            lookup_count_d = lookup_count_q + STAT_WIDTH'(1);
         end
      end

      if (mp_event && (mispredict_count_q != '1)) begin
         mispredict_count_d = mispredict_count_q + STAT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid_q       <= 1'b0;
         pred_taken_q       <= 1'b0;
         pred_from_table_q  <= 1'b0;
         mispredict_q       <= 1'b0;
         mispredict_count_q <= '0;
         lookup_count_q     <= '0;
      end else begin
         pred_valid_q       <= pred_valid_d;
         pred_taken_q       <= pred_taken_d;
         pred_from_table_q  <= pred_from_table_d;
         mispredict_q       <= mispredict_d;
         mispredict_count_q <= mispredict_count_d;
         lookup_count_q     <= lookup_count_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign pred_from_table  = pred_from_table_q;
   assign mispredict       = mispredict_q;
   assign mispredict_count = mispredict_count_q;
   assign lookup_count     = lookup_count_q;

endmodule

// File: tb/tb_branch_pattern_table.sv
// Directed and random checks of branch_pattern_table against a table-of-ints
// reference model evaluated once per clock edge.
module tb_branch_pattern_table;

   logic       clk = 1'b0;
   logic       rst;
   logic       pred_req;
   logic [9:0] pred_pc;
   logic [2:0] read_history;
   logic       read_hit;
   logic       pred_valid, pred_taken, pred_from_table;
   logic       upd_valid;
   logic [9:0] upd_pc;
   logic [2:0] upd_history;
   logic       upd_evict, upd_taken, upd_pred_taken;
   logic       mispredict;
   logic [15:0] mispredict_count, lookup_count;

   always #5 clk = ~clk;

   branch_pattern_table dut (
      .clk              (clk),
      .rst              (rst),
      .pred_req         (pred_req),
      .pred_pc          (pred_pc),
      .read_history     (read_history),
      .read_hit         (read_hit),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .pred_from_table  (pred_from_table),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_history      (upd_history),
      .upd_evict        (upd_evict),
      .upd_taken        (upd_taken),
      .upd_pred_taken   (upd_pred_taken),
      .mispredict       (mispredict),
      .mispredict_count (mispredict_count),
      .lookup_count     (lookup_count)
   );

   int errors = 0;
   int checks = 0;

   int m_ctr [32];
   int m_pv, m_pt, m_pf, m_mp, m_mc, m_lc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [9:0] pc, input logic [2:0] h);
      return (int'(pc) % 4) * 8 + int'(h);
   endfunction

   // Table is trained first, then read, so collisions see the new value.
   task automatic model_edge();
      int i;
      if (rst) begin
         for (int k = 0; k < 32; k++) m_ctr[k] = 1;
         m_pv = 0; m_pt = 0; m_pf = 0; m_mp = 0; m_mc = 0; m_lc = 0;
      end else begin
         if (upd_valid) begin
            i = idx_of(upd_pc, upd_history);
            if (upd_evict)      m_ctr[i] = upd_taken ? 2 : 1;
            else if (upd_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
         m_mp = (upd_valid && (upd_taken != upd_pred_taken)) ? 1 : 0;
         if (m_mp == 1 && m_mc < 65535) m_mc++;
         if (pred_req) begin
            m_pv = 1;
            m_pf = read_hit ? 1 : 0;
            m_pt = (read_hit && m_ctr[idx_of(pred_pc, read_history)] >= 2) ? 1 : 0;
            if (m_lc < 65535) m_lc++;
         end else begin
            m_pv = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("pred_valid",       32'(pred_valid),       32'(m_pv));
      chk("pred_taken",       32'(pred_taken),       32'(m_pt));
      chk("pred_from_table",  32'(pred_from_table),  32'(m_pf));
      chk("mispredict",       32'(mispredict),       32'(m_mp));
      chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
      chk("lookup_count",     32'(lookup_count),     32'(m_lc));
   endtask

   task automatic idle();
      pred_req = 1'b0; read_hit = 1'b0; pred_pc = '0; read_history = '0;
      upd_valid = 1'b0; upd_evict = 1'b0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
      upd_pc = '0; upd_history = '0;
   endtask

   task automatic lookup(input logic [9:0] pc, input logic [2:0] h, input logic hit);
      pred_req = 1'b1; pred_pc = pc; read_history = h; read_hit = hit;
   endtask

   task automatic upd(input logic [9:0] pc, input logic [2:0] h, input logic ev,
                      input logic tk, input logic ptk);
      upd_valid = 1'b1; upd_pc = pc; upd_history = h; upd_evict = ev;
      upd_taken = tk; upd_pred_taken = ptk;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      step();
      step();
      chk("reset_pred_valid", 32'(pred_valid), 32'd0);
      chk("reset_lookup_count", 32'(lookup_count), 32'd0);
      rst = 1'b0;

      // First lookup after reset: weakly not-taken from table.
      lookup(10'h005, 3'b101, 1'b1);
      step();
      chk("first_pt", 32'(pred_taken), 32'd0);
      chk("first_pf", 32'(pred_from_table), 32'd1);
      chk("first_lc", 32'(lookup_count), 32'd1);
      idle();

      // Train 01 -> 10 -> 11 -> 11.
      for (int k = 0; k < 3; k++) begin
         upd(10'h005, 3'b101, 1'b0, 1'b1, 1'b1);
         step();
      end
      idle();
      lookup(10'h005, 3'b101, 1'b1);
      step();
      chk("trained_pt", 32'(pred_taken), 32'd1);
      idle();
      upd(10'h005, 3'b101, 1'b0, 1'b1, 1'b1);
      step();
      idle();
      lookup(10'h005, 3'b101, 1'b1);
      step();
      chk("saturated_pt", 32'(pred_taken), 32'd1);

      lookup(10'h005, 3'b101, 1'b0);
      step();
      chk("miss_pt", 32'(pred_taken), 32'd0);
      chk("miss_pf", 32'(pred_from_table), 32'd0);

      // Evict not-taken with same-cycle lookup: bypass sees 01.
      upd(10'h005, 3'b101, 1'b1, 1'b0, 1'b0);
      lookup(10'h005, 3'b101, 1'b1);
      step();
      chk("bypass_pt", 32'(pred_taken), 32'd0);
      idle();

      upd(10'h005, 3'b101, 1'b0, 1'b1, 1'b0);
      step();
      chk("mp_pulse", 32'(mispredict), 32'd1);
      chk("mp_count", 32'(mispredict_count), 32'd1);
      idle();
      step();
      chk("mp_pulse_end", 32'(mispredict), 32'd0);

      // Random mix of lookups, updates, evicts and collisions.
      for (int n = 0; n < 600; n++) begin
         pred_req       = 1'($urandom_range(0, 1));
         read_hit       = 1'($urandom_range(0, 3) != 0);
         pred_pc        = 10'($urandom);
         read_history   = 3'($urandom);
         upd_valid      = 1'($urandom_range(0, 1));
         upd_evict      = 1'($urandom_range(0, 7) == 0);
         upd_taken      = 1'($urandom_range(0, 1));
         upd_pred_taken = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            upd_pc = pred_pc; upd_history = read_history;
         end else begin
            upd_pc = 10'($urandom); upd_history = 3'($urandom);
         end
         step();
      end
      idle();

      // Drive the mispredict counter past its ceiling.
      for (int n = 0; n < 70000; n++) begin
         upd(10'($urandom), 3'($urandom), 1'b0, 1'b1, 1'b0);
         step();
      end
      chk("mp_count_sat", 32'(mispredict_count), 32'h0000_FFFF);
      idle();

      // Reset mid-stream overrides concurrent traffic.
      upd(10'h005, 3'b101, 1'b0, 1'b1, 1'b0);
      lookup(10'h005, 3'b101, 1'b1);
      rst = 1'b1;
      step();
      chk("rst_pv", 32'(pred_valid), 32'd0);
      chk("rst_mp", 32'(mispredict), 32'd0);
      rst = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) begin
         lookup(10'(i / 8), 3'(i % 8), 1'b1);
         step();
         chk("rst_ctr_pt", 32'(pred_taken), 32'd0);
      end
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
- Second level of the local-history branch predictor. Sits directly downstream of the per-PC branch history cache.
- Consumes the cache's read_history/read_hit at fetch and produces a registered taken/not-taken prediction one cycle later.
- Consumes the cache's update_history/evict at branch resolution to train a table of 2-bit saturating counters. Also maintains mispredict and lookup statistics.

Parameters:
PC_IDX_BITS, 2, low PC bits concatenated with history to form the table index
HIST_BITS, 3, history width; must equal the cache history width
CTR_BITS, 2, saturating counter width
STAT_WIDTH, 16, width of the statistics counters
(derived) ENTRIES = 2**(PC_IDX_BITS+HIST_BITS) = 32

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pred_req  in  1  fetch lookup request this cycle
pred_pc  in  10  fetch PC (same value driven to cache pc)
read_history  in  HIST_BITS  history from cache for pred_pc
read_hit  in  1  cache hit for pred_pc
pred_valid  out  1  registered: prediction below is valid
pred_taken  out  1  registered predicted direction
pred_from_table  out  1  registered: 1 = table-based, 0 = static fallback
upd_valid  in  1  branch resolved this cycle
upd_pc  in  10  resolved branch PC (same value driven to cache update_pc)
upd_history  in  HIST_BITS  cache update_history (history before this outcome)
upd_evict  in  1  cache evict for this update
upd_taken  in  1  actual outcome
upd_pred_taken  in  1  direction that was predicted for this branch
mispredict  out  1  registered one-cycle pulse: upd_valid && upd_taken != upd_pred_taken
mispredict_count  out  STAT_WIDTH  saturating mispredict count
lookup_count  out  STAT_WIDTH  saturating count of pred_req cycles

Behaviour:
- Index = {pc[PC_IDX_BITS-1:0], history}. Lookup index uses pred_pc/read_history; update index uses upd_pc/upd_history.
- Reset (rst=1 at a clock edge):
  - all counters set to 2'b01 (weakly not-taken);
  - pred_valid, pred_taken, pred_from_table, mispredict = 0; both stat counters = 0.
  - rst overrides any concurrent pred_req/upd_valid. Inputs sampled on a reset cycle are dropped, with no output in the following cycle.
- Prediction, latency 1:
  - on edge with pred_req=1: pred_valid<=1.
  - read_hit=1: pred_taken <= counter MSB, pred_from_table <= 1.
  - read_hit=0: pred_taken <= 0 (static not-taken), pred_from_table <= 0.
  - pred_req=0: pred_valid<=0; pred_taken/pred_from_table hold their previous values.
- Update, write at edge:
  - upd_valid=1, upd_evict=0: counter[idx] increments if upd_taken, else decrements.
    - Saturates at 3 and 0. Never wraps.
  - upd_valid=1, upd_evict=1: new cache entry, so stale training is discarded.
    - counter[idx] <= upd_taken ? 2'b10 : 2'b01 (weak in outcome direction).
  - upd_valid=0: table unchanged.
- Simultaneous lookup and update, same index, same cycle:
  - prediction uses the post-update counter value (write-first bypass).
  - Different indices are independent.
- Statistics:
  - mispredict pulse registered from the update cycle.
  - mispredict_count increments on each mispredict, evict or not.
  - lookup_count increments on each pred_req.
  - Both saturate at all-ones.
- No backpressure: one lookup and one update are accepted per cycle, every cycle.

Decomposition:
- Shared package bp_pkg holds:
  - HIST_BITS, CTR_BITS, counter reset constant CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10;
  - function sat_update(ctr, taken).
- Sub-module sat_counter: one CTR_BITS counter with we, init, init_val, taken inputs.
  - Instantiated as an ENTRIES-element array, the same way the cache builds its history table.
- Stats counters stay inline.

Test Plan:
- Reset, then pred_req with pred_pc=0x005, read_history=3'b101, read_hit=1 -> next cycle pred_valid=1, pred_taken=0, pred_from_table=1; all stats 0 except lookup_count=1.
- 3 updates, upd_pc=0x005, upd_history=3'b101, taken=1, evict=0 -> counter goes 01->10->11->11. Lookup at that index then gives pred_taken=1. A 4th taken update keeps the counter at 11.
- read_hit=0 on a trained index (counter 11) -> pred_taken=0, pred_from_table=0.
- Update with upd_evict=1, taken=0 on index of counter 11 -> counter=01. Same-cycle lookup at that index -> pred_taken=0 (bypass).
- upd_taken=1, upd_pred_taken=0 -> mispredict=1 for exactly one cycle, mispredict_count +1. Drive 70000 mispredicts with STAT_WIDTH=16 -> count holds at 0xFFFF.
- Assert rst mid-stream with pred_req=1 and upd_valid=1 -> next cycle pred_valid=0, mispredict=0, and all counters read back 01.
